spi_device: RTL
===============

SPI_DEVICE -- requirements
Module: spi_device

Interface
REQ-001 SHALL have parameter CPOL, default 0, SCK idle level.
REQ-002 SHALL have parameter CPHA, default 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 SHALL have parameter RxDepth, default 16, RX FIFO entries (2..127).
REQ-004 SHALL have ports:
  - clk_i  in  1  system clock
  - rst_ni  in  1  reset, asynchronous, active-low
  - device_req_i  in  1  bus request
  - device_addr_i  in  32  byte address; bits [11:0] decoded
  - device_we_i  in  1  write enable
  - device_be_i  in  4  byte enables; unused
  - device_wdata_i  in  32  write data
  - device_rvalid_o  out  1  response valid
  - device_rdata_o  out  32  read data
  - spi_sck_i  in  1  SCK from the external host
  - spi_csn_i  in  1  chip select, active-low
  - spi_mosi_i  in  1  host-to-device data
  - spi_miso_o  out  1  device-to-host data

Function
REQ-005 SHALL pass spi_sck_i, spi_csn_i and spi_mosi_i through 2-flop synchronizers to clk_i, and detect edges from the synchronized values.
REQ-006 SHALL support f_sck <= f_clk/8; faster SCK is undefined.
REQ-007 SHALL implement FSM IDLE/SHIFT: IDLE->SHIFT on synchronized csn falling; SHIFT->IDLE on csn rising.
REQ-008 SHALL, on SHIFT entry, clear the 3-bit bit counter and load the TX shift register from TX_REG, or 0xFF if TX_REG is not valid.
REQ-009 SHALL sample MOSI MSB-first on the leading SCK edge (away from CPOL) when CPHA=0, and on the trailing edge when CPHA=1.
REQ-010 SHALL drive MISO = TX shift MSB; the shift advances on the non-sampling edge, except the first non-sampling edge when CPHA=1.
REQ-011 SHALL hold spi_miso_o at 1 in IDLE.
REQ-012 SHALL, on the 8th sample (bit counter wraps 7->0), push the byte to the RX FIFO in the same cycle and reload TX shift per REQ-008.
REQ-013 SHALL, on a push while the FIFO is full, drop the byte and set sticky rx_overflow.
REQ-014 SHALL discard a partial byte on csn rising; no push.
REQ-015 SHALL provide registers:
  - 0x0 RX_DATA (RO): rdata[7:0] = FIFO head; a read pops; reading an empty FIFO returns 0 with no pop.
  - 0x4 STATUS: rdata = {28'b0, active, rx_overflow, rx_full, rx_empty}; a write of bit2=1 clears rx_overflow.
  - 0x8 TX_REG (WO): wdata[7:0] stored and valid set; valid is cleared when the byte is loaded into the shifter.
REQ-016 SHALL assert device_rvalid_o exactly 1 cycle after every device_req_i, for reads and writes.
REQ-017 SHALL register device_rdata_o; it is 0 for writes and unmapped addresses.
REQ-018 SHALL, on a simultaneous push and pop, perform both; depth unchanged; no overflow even when full.
REQ-019 SHALL, when a TX_REG write coincides with a shifter load, load the new byte and leave valid cleared.

Reset
REQ-020 SHALL reset to: FSM IDLE, counters 0, shifters 0xFF, RX FIFO empty, rx_overflow 0, TX valid 0, spi_miso_o 1, device_rvalid_o 0, device_rdata_o 0.
REQ-021 SHALL, on reset during SHIFT, abandon the transfer; after reset, return to SHIFT only on a new csn falling edge.

Structure
REQ-022 SHALL take register offsets (0x0, 0x4, 0x8), the state enum and status bit positions from shared package spi_pkg.
REQ-023 SHALL build the RX FIFO from prim_fifo_sync (Width 8, Pass 0); shift/FSM logic is inline, no other sub-module.

Verification
REQ-024 CPOL=0, CPHA=0; host sends 0xA5 with TX_REG=0x3C -> MOSI capture 0xA5 read at 0x0; host receives 0x3C.
REQ-025 CPOL=1, CPHA=1; three bytes 0x01, 0x80, 0xFF -> three reads return the same order; STATUS then reads 0x1.
REQ-026 RxDepth=16; 17 bytes, no reads -> STATUS=0x6; 16 reads return bytes 1..16; write 0x4 to STATUS -> overflow cleared.
REQ-027 csn rises after 5 bits -> FIFO stays empty; next full byte 0x5A is received correctly.
REQ-028 No TX_REG write -> host receives 0xFF; read of empty RX_DATA -> rdata 0, rvalid 1 cycle after req.
REQ-029 rst_ni pulsed mid-byte -> all outputs at REQ-020 values; next transfer of 0xC3 is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI device register block and shift engine.
package spi_pkg;

    localparam int unsigned AddrW   = 12;
    localparam int unsigned ByteW   = 8;
    localparam int unsigned BitCntW = 3;
    localparam int unsigned DataW   = 32;

    localparam logic [AddrW-1:0] RxDataOffset = 12'h0;
    localparam logic [AddrW-1:0] StatusOffset = 12'h4;
    localparam logic [AddrW-1:0] TxRegOffset  = 12'h8;

    localparam int unsigned StatusEmptyBit  = 0;
    localparam int unsigned StatusFullBit   = 1;
    localparam int unsigned StatusOvfBit    = 2;
    localparam int unsigned StatusActiveBit = 3;

    // Byte shifted out when software has not queued a TX byte.
    localparam logic [ByteW-1:0] TxIdleByte = 8'hFF;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } spi_state_e;

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO; a write is accepted when full if a read happens in the same cycle.
module prim_fifo_sync #(
    parameter int unsigned Width = 8,
    parameter bit          Pass  = 1'b0,
    parameter int unsigned Depth = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wvalid_i,
    output logic             wready_o,
    input  logic [Width-1:0] wdata_i,
    output logic             rvalid_o,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             empty, pass, push, pop, store, take;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign empty    = (cnt_q == '0);
    assign full_o   = (cnt_q == CntW'(Depth));
    assign pass     = Pass && empty && wvalid_i;
    assign rvalid_o = !empty || pass;
    assign rdata_o  = empty ? wdata_i : mem_q[rptr_q];
    assign wready_o = !full_o || rready_i;
    assign push     = wvalid_i && wready_o;
    assign pop      = rvalid_o && rready_i;
    assign store    = push && !(pass && pop);
    assign take     = pop && !empty;

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (store) wptr_q <= ptr_inc(wptr_q);
            if (take)  rptr_q <= ptr_inc(rptr_q);
            if (store && !take)      cnt_q <= cnt_q + CntW'(1);
            else if (!store && take) cnt_q <= cnt_q - CntW'(1);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk_i) begin
        if (store) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spi_device.sv
// SPI device: oversampled SPI slave with RX FIFO, TX holding register and a small register bus.
module spi_device
    import spi_pkg::*;
#(
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0,
    parameter int unsigned RxDepth = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             device_req_i,
    input  logic [DataW-1:0] device_addr_i,
    input  logic             device_we_i,
    input  logic [3:0]       device_be_i,
    input  logic [DataW-1:0] device_wdata_i,
    output logic             device_rvalid_o,
    output logic [DataW-1:0] device_rdata_o,
    input  logic             spi_sck_i,
    input  logic             spi_csn_i,
    input  logic             spi_mosi_i,
    output logic             spi_miso_o
);

    logic [1:0]       sck_sync_q, csn_sync_q, mosi_sync_q;
    logic             sck_prev_q, csn_prev_q;
    logic             sck_s, csn_s, mosi_s;
    logic             lead_edge, trail_edge, sample_edge, shift_edge, csn_fall, csn_rise;
    spi_state_e       state_q, state_d;
    logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [ByteW-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [ByteW-1:0] tx_reg_q;
    logic             tx_valid_q, rx_ovf_q, miso_q;
    logic             rx_push, tx_load;
    logic [AddrW-1:0] addr;
    logic             bus_rd, bus_wr, rx_pop, tx_wr, ovf_clr;
    logic             fifo_wready, fifo_rvalid, fifo_full;
    logic [ByteW-1:0] fifo_rdata;
    logic             rvalid_q;
    logic [DataW-1:0] rdata_q, rdata_d;
    logic             unused_bits;

    // csn sync flops reset low so a csn held low across reset never looks like a new falling edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q  <= {2{CPOL}};
            sck_prev_q  <= CPOL;
            csn_sync_q  <= 2'b00;
            csn_prev_q  <= 1'b0;
            mosi_sync_q <= 2'b00;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], spi_sck_i};
            sck_prev_q  <= sck_sync_q[1];
            csn_sync_q  <= {csn_sync_q[0], spi_csn_i};
            csn_prev_q  <= csn_sync_q[1];
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
        end
    end

    assign sck_s       = sck_sync_q[1];
    assign csn_s       = csn_sync_q[1];
    assign mosi_s      = mosi_sync_q[1];
    assign lead_edge   = (sck_prev_q == CPOL) && (sck_s != CPOL);
    assign trail_edge  = (sck_prev_q != CPOL) && (sck_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign csn_fall    = csn_prev_q && !csn_s;
    assign csn_rise    = !csn_prev_q && csn_s;

    assign addr    = device_addr_i[AddrW-1:0];
    assign bus_rd  = device_req_i && !device_we_i;
    assign bus_wr  = device_req_i && device_we_i;
    assign rx_pop  = bus_rd && (addr == RxDataOffset) && fifo_rvalid;
    assign tx_wr   = bus_wr && (addr == TxRegOffset);
    assign ovf_clr = bus_wr && (addr == StatusOffset) && device_wdata_i[StatusOvfBit];

    // Next-state and shift datapath; the shift edge is skipped at bit 0 so a freshly loaded MSB stays on MISO.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        rx_push    = 1'b0;
        tx_load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (csn_fall) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                    tx_load   = 1'b1;
                end
            end
            StShift: begin
                if (csn_rise) begin
                    state_d = StIdle;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[ByteW-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + BitCntW'(1);
                    if (bit_cnt_q == BitCntW'(ByteW - 1)) begin
                        rx_push = 1'b1;
                        tx_load = 1'b1;
                    end
                end else if (shift_edge && (bit_cnt_q != '0)) begin
                    tx_shift_d = {tx_shift_q[ByteW-2:0], 1'b1};
                end
            end
            default: state_d = StIdle;
        endcase
        if (tx_load) begin
            tx_shift_d = tx_wr ? device_wdata_i[ByteW-1:0] : (tx_valid_q ? tx_reg_q : TxIdleByte);
        end
    end

    // FSM, shifters, TX holding register, overflow flag and MISO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_shift_q <= 8'hFF;
            tx_shift_q <= 8'hFF;
            tx_reg_q   <= '0;
            tx_valid_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            miso_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            if (tx_wr) tx_reg_q <= device_wdata_i[ByteW-1:0];
            if (tx_load)    tx_valid_q <= 1'b0;
            else if (tx_wr) tx_valid_q <= 1'b1;
            if (rx_push && !fifo_wready) rx_ovf_q <= 1'b1;
            else if (ovf_clr)            rx_ovf_q <= 1'b0;
            miso_q <= (state_d == StShift) ? tx_shift_d[ByteW-1] : 1'b1;
        end
    end

    prim_fifo_sync #(
        .Width(ByteW),
        .Pass (1'b0),
        .Depth(RxDepth)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wvalid_i(rx_push),
        .wready_o(fifo_wready),
        .wdata_i (rx_shift_d),
        .rvalid_o(fifo_rvalid),
        .rready_i(rx_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full)
    );

    // Read data mux; writes and unmapped addresses return zero.
    always_comb begin
        rdata_d = '0;
        if (bus_rd) begin
            case (addr)
                RxDataOffset: rdata_d = fifo_rvalid ? DataW'(fifo_rdata) : '0;
                StatusOffset: begin
                    rdata_d[StatusEmptyBit]  = !fifo_rvalid;
                    rdata_d[StatusFullBit]   = fifo_full;
                    rdata_d[StatusOvfBit]    = rx_ovf_q;
                    rdata_d[StatusActiveBit] = (state_q == StShift);
                end
                default: rdata_d = '0;
            endcase
        end
    end

    // Single-cycle bus response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= device_req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign spi_miso_o      = miso_q;
    assign unused_bits     = ^{device_be_i, device_addr_i[DataW-1:AddrW], device_wdata_i[DataW-1:ByteW]};

endmodule
